uart_rx_async: RTL and testbench
================================

# uart_rx_async

Asynchronous UART receiver: recovers serial frames from the line `rx` using a 16x oversampling baud pulse, checks parity and stop bit, and presents each received byte in a single holding register with valid/read handshake and error flags. Sits in the CoreUART datapath as the receive counterpart of the transmit engine, sharing the same baud generator pulse and the same `bit8`/`parity_en`/`odd_n_even` control register fields.

## Interface
- `SYNC_STAGES`, 2, number of flops in the `rx` input synchronizer (min 2).

- `clk` in 1 system clock
- `aresetn` in 1 asynchronous, active-low reset; clock `clk`
- `baud_pulse` in 1 one-`clk`-wide strobe at 16x bit rate
- `rx` in 1 asynchronous serial line, idle high
- `bit8` in 1 1 = 8 data bits, 0 = 7 data bits
- `parity_en` in 1 parity bit present after data
- `odd_n_even` in 1 1 = odd parity, 0 = even
- `rd_strobe` in 1 one-cycle read of holding register
- `rx_data` out 8 received byte, LSB first on line; bit 7 = 0 in 7-bit mode
- `rx_valid` out 1 holding register full
- `parity_err` out 1 parity mismatch for byte in `rx_data`
- `framing_err` out 1 stop bit sampled low for byte in `rx_data`
- `overrun` out 1 sticky: a frame completed while `rx_valid`=1
- `rx_busy` out 1 FSM not in IDLE

## Operation
- Reset values: `rx_data`=0x00; `rx_valid`, `parity_err`, `framing_err`, `overrun`, `rx_busy`=0; synchronizer flops=1; FSM IDLE.
- `rx` passes through `SYNC_STAGES` flops; falling edge detected on synchronized value (1 then 0).
- `samp_cnt` (4 bits) clears on start detection, increments mod 16 on each `baud_pulse`. Decision point DEC = `samp_cnt`==7 on a `baud_pulse` (see Configuration).
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on falling edge -> START, clear `samp_cnt`, `bit_cnt`, parity accumulator.
  - START: at DEC, bit=1 -> IDLE (false start, nothing loaded); bit=0 -> DATA.
  - DATA: at DEC, shift bit into `shift_reg[bit_cnt]`, XOR into accumulator, increment `bit_cnt`; after bit 7 (bit8=1) or bit 6 (bit8=0) -> PARITY if `parity_en`, else STOP.
  - PARITY: at DEC, `perr` = sampled bit != (`odd_n_even` ^ accumulator) -> STOP.
  - STOP: at DEC, `ferr` = (bit==0); load holding register; -> IDLE.
- Load: if `rx_valid`=0, or `rd_strobe` in same cycle: `rx_data`, `parity_err` (0 when parity disabled), `framing_err` update; `rx_valid`=1. Otherwise holding register and flags unchanged, new frame discarded, `overrun`=1.
- `rd_strobe` with `rx_valid`=1 and no load: `rx_valid`=0, `overrun`=0. `rd_strobe` with `rx_valid`=0: no effect.
- Line held low after STOP (break): no new start until `rx` returns high, then falls.
- Control inputs sampled live; changing them mid-frame is undefined.

## Timing
- Start detection: `SYNC_STAGES`+1 `clk` after `rx` falls.
- Bit decisions every 16 `baud_pulse` after START decision.
- Outputs registered; `rx_valid` and data rise the `clk` after the STOP decision pulse.
- `rd_strobe` effect visible next `clk`.
- `aresetn` asserted mid-frame: all state returns to reset values immediately; partial frame lost.

## Configuration
- `UART_RX_MAJORITY_EN` defined: bit value = majority of samples at `samp_cnt` 6, 7, 8; DEC moves to `samp_cnt`==8 (one `baud_pulse` later per bit).
- Undefined: single sample at `samp_cnt`==7; no sample history flops.

## Structure
- Shared package `uart_pkg`: FSM state enum `rx_state_t`, `SAMP_DEC` constant (7/8 per macro), `OVERSAMPLE`=16.
- Sub-module `uart_rx_sync`: `SYNC_STAGES` synchronizer plus falling-edge detect, reused by any future line input.

## Test plan
- 8N1, send 0xA5 -> `rx_data`=0xA5, `rx_valid`=1, all error flags 0; `rd_strobe` -> `rx_valid`=0.
- 7E1 (`bit8`=0, `parity_en`=1, `odd_n_even`=0), send 0x35 with parity bit 1 -> `rx_data`=0x35, `parity_err`=1; parity bit 0 -> `parity_err`=0.
- 8N1, send 0x3C with stop bit 0 -> `rx_data`=0x3C, `framing_err`=1; line stays low 40 bits -> no further `rx_valid`.
- Low glitch of 4 `baud_pulse` on idle line -> FSM back to IDLE, `rx_valid` stays 0.
- Send 0x11 then 0x22 without reading -> `rx_data`=0x11, `overrun`=1; `rd_strobe` on same cycle as second load instead -> `rx_data`=0x22, `overrun`=0.
- Assert `aresetn` during bit 4 of a frame, release, send 0x5A -> `rx_data`=0x5A, no stale data or flags.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions for the receive path.
//   rx_state_t : receiver FSM states
//   OVERSAMPLE : baud pulses per bit
//   SAMP_DEC   : samp_cnt value at which a bit decision is taken
// Build option: UART_RX_MAJORITY_EN moves the decision to the third of three
// samples (6, 7, 8) and enables majority voting in uart_rx_async.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;

`ifdef UART_RX_MAJORITY_EN
  localparam int unsigned SAMP_DEC = 8;
`else
  localparam int unsigned SAMP_DEC = 7;
`endif

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Line input synchronizer with falling-edge detect.
//   clk, aresetn : clock, async active-low reset
//   d_i          : asynchronous line input (idle high)
//   q_o          : synchronized line value
//   fall_o       : synchronized value went 1 -> 0 (one cycle)
// SYNC_STAGES must be at least 2. All flops reset to 1 (idle line).
module uart_rx_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic aresetn,
  input  logic d_i,
  output logic q_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign q_o    = sync_q[SYNC_STAGES-1];
  assign fall_o = prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_async.sv
// Asynchronous UART receiver with 16x oversampling and a single holding register.
//   clk, aresetn   : clock, async active-low reset
//   baud_pulse_i   : one-cycle strobe at 16x bit rate
//   rx_i           : serial line, idle high
//   bit8_i         : 1 = 8 data bits, 0 = 7
//   parity_en_i    : parity bit follows data
//   odd_n_even_i   : 1 = odd parity, 0 = even
//   rd_strobe_i    : read (empties) the holding register
//   rx_data_o      : received byte (bit 7 = 0 in 7-bit mode)
//   rx_valid_o     : holding register full
//   parity_err_o   : parity mismatch for rx_data_o
//   framing_err_o  : stop bit sampled low for rx_data_o
//   overrun_o      : sticky, a frame was dropped because the register was full
//   rx_busy_o      : receiver FSM not idle
// Build option: UART_RX_MAJORITY_EN selects 3-sample majority bit decisions.
module uart_rx_async
  import uart_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       aresetn,
  input  logic       baud_pulse_i,
  input  logic       rx_i,
  input  logic       bit8_i,
  input  logic       parity_en_i,
  input  logic       odd_n_even_i,
  input  logic       rd_strobe_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       parity_err_o,
  output logic       framing_err_o,
  output logic       overrun_o,
  output logic       rx_busy_o
);

  localparam int unsigned SampW = $clog2(OVERSAMPLE);

  rx_state_t        state_q, state_d;
  logic [SampW-1:0] samp_cnt_q, samp_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             acc_q, acc_d;
  logic             perr_q, perr_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             parity_err_q, parity_err_d;
  logic             framing_err_q, framing_err_d;
  logic             overrun_q, overrun_d;

  logic rx_s, rx_fall, samp_bit, dec, load_req, ferr;

  uart_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .aresetn(aresetn),
    .d_i    (rx_i),
    .q_o    (rx_s),
    .fall_o (rx_fall)
  );

  assign dec = baud_pulse_i && (samp_cnt_q == SampW'(SAMP_DEC));

`ifdef UART_RX_MAJORITY_EN
  // Samples taken at samp_cnt 6 and 7; the third is the live value at DEC (8).
  logic [1:0] hist_q;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      hist_q <= 2'b11;
    end else if (baud_pulse_i) begin
      if (samp_cnt_q == SampW'(SAMP_DEC - 2)) hist_q[0] <= rx_s;
      if (samp_cnt_q == SampW'(SAMP_DEC - 1)) hist_q[1] <= rx_s;
    end
  end

  assign samp_bit = (hist_q[0] & hist_q[1]) | (hist_q[0] & rx_s) | (hist_q[1] & rx_s);
`else
  assign samp_bit = rx_s;
`endif

  // Frame FSM and bit assembly
  always_comb begin
    state_d    = state_q;
    samp_cnt_d = samp_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    acc_d      = acc_q;
    perr_d     = perr_q;
    load_req   = 1'b0;
    ferr       = 1'b0;
    if (baud_pulse_i) samp_cnt_d = samp_cnt_q + 1'b1;
    unique case (state_q)
      StIdle: begin
        if (rx_fall) begin
          state_d    = StStart;
          samp_cnt_d = '0;
          bit_cnt_d  = '0;
          shift_d    = '0;  // keeps bit 7 clear in 7-bit mode
          acc_d      = 1'b0;
          perr_d     = 1'b0;
        end
      end
      StStart: begin
        if (dec) state_d = samp_bit ? StIdle : StData;
      end
      StData: begin
        if (dec) begin
          shift_d[bit_cnt_q] = samp_bit;
          acc_d              = acc_q ^ samp_bit;
          bit_cnt_d          = bit_cnt_q + 3'd1;
          if (bit_cnt_q == (bit8_i ? 3'd7 : 3'd6)) begin
            state_d = parity_en_i ? StParity : StStop;
          end
        end
      end
      StParity: begin
        if (dec) begin
          perr_d  = samp_bit != (odd_n_even_i ^ acc_q);
          state_d = StStop;
        end
      end
      StStop: begin
        if (dec) begin
          ferr     = ~samp_bit;
          load_req = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Holding register and handshake
  always_comb begin
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    parity_err_d  = parity_err_q;
    framing_err_d = framing_err_q;
    overrun_d     = overrun_q;
    if (load_req) begin
      if (!rx_valid_q || rd_strobe_i) begin
        rx_data_d     = shift_q;
        parity_err_d  = perr_q;
        framing_err_d = ferr;
        rx_valid_d    = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rd_strobe_i && rx_valid_q) begin
      rx_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= StIdle;
      samp_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      acc_q         <= 1'b0;
      perr_q        <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      parity_err_q  <= 1'b0;
      framing_err_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      samp_cnt_q    <= samp_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      acc_q         <= acc_d;
      perr_q        <= perr_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      parity_err_q  <= parity_err_d;
      framing_err_q <= framing_err_d;
      overrun_q     <= overrun_d;
    end
  end

  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign parity_err_o  = parity_err_q;
  assign framing_err_o = framing_err_q;
  assign overrun_o     = overrun_q;
  assign rx_busy_o     = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_async.sv
// Bench for uart_rx_async: directed frames, a frame-level model of the holding
// register, and a per-cycle compare against that model.
module tb_uart_rx_async;

  localparam int P       = 4;       // clk per baud pulse
  localparam int BIT_CLK = 16 * P;  // clk per bit
  localparam int SYNC    = 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int DecOff = 9;
`else
  localparam int DecOff = 8;
`endif

  logic       clk = 1'b0;
  logic       aresetn, baud_pulse, rx, bit8, parity_en, odd_n_even, rd_strobe;
  logic [7:0] rx_data;
  logic       rx_valid, parity_err, framing_err, overrun, rx_busy;

  uart_rx_async #(
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk          (clk),
    .aresetn      (aresetn),
    .baud_pulse_i (baud_pulse),
    .rx_i         (rx),
    .bit8_i       (bit8),
    .parity_en_i  (parity_en),
    .odd_n_even_i (odd_n_even),
    .rd_strobe_i  (rd_strobe),
    .rx_data_o    (rx_data),
    .rx_valid_o   (rx_valid),
    .parity_err_o (parity_err),
    .framing_err_o(framing_err),
    .overrun_o    (overrun),
    .rx_busy_o    (rx_busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int pc    = 0;

  // Expected holding-register state
  logic [7:0] m_data;
  logic       m_valid, m_perr, m_ferr, m_ovr;
  bit         chk_on = 1'b0;

  task automatic model_reset();
    m_data = 8'h00; m_valid = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic model_load(input logic [7:0] d, input logic pe, input logic fe, input bit rd);
    if (!m_valid || rd) begin
      m_data = d; m_perr = pe; m_ferr = fe; m_valid = 1'b1;
    end else begin
      m_ovr = 1'b1;
    end
  endtask

  task automatic model_read();
    if (m_valid) begin
      m_valid = 1'b0; m_ovr = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      total++;
      if ({rx_data, rx_valid, parity_err, framing_err, overrun} !==
          {m_data, m_valid, m_perr, m_ferr, m_ovr}) begin
        bad++;
        if (bad < 20)
          $display("FAIL cycle_cmp t=%0t got data=%h v=%b pe=%b fe=%b ov=%b exp data=%h v=%b pe=%b fe=%b ov=%b",
                   $time, rx_data, rx_valid, parity_err, framing_err, overrun,
                   m_data, m_valid, m_perr, m_ferr, m_ovr);
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Advance one clock; leaves us 1 time unit after the edge with next-cycle baud_pulse driven.
  task automatic tick();
    @(posedge clk);
    #1;
    pc = (pc == P - 1) ? 0 : pc + 1;
    baud_pulse = (pc == 0);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) tick();
  endtask

  task automatic do_read();
    rd_strobe = 1'b1;
    tick();
    rd_strobe = 1'b0;
    model_read();
  endtask

  // Drive one frame. cut >= 0 abandons the frame after that many clocks.
  task automatic send_frame(input logic [7:0] val, input logic pbit, input logic stop_v,
                            input bit rd_at_load, input int cut);
    logic [11:0] line;
    logic [7:0]  e_data;
    logic        e_perr, good_par;
    int          n, nd, pulses, dec_idx, ones;
    bit          load_now;
    nd = bit8 ? 8 : 7;
    line = '1;
    line[0] = 1'b0;
    for (int i = 0; i < nd; i++) line[1+i] = val[i];
    n = 1 + nd;
    if (parity_en) begin
      line[n] = pbit;
      n++;
    end
    line[n] = stop_v;
    n++;
    e_data   = bit8 ? val : {1'b0, val[6:0]};
    ones     = $countones(e_data);
    good_par = odd_n_even ? (ones % 2 == 0) : (ones % 2 == 1);
    e_perr   = parity_en && (pbit != good_par);
    // Stop decision: DecOff-th pulse after detection, plus 16 per preceding bit.
    dec_idx  = (n - 1) * 16 + DecOff;
    pulses   = 0;
    load_now = 1'b0;
    for (int c = 0; c < n * BIT_CLK; c++) begin
      if (cut >= 0 && c == cut) return;
      if (c == BIT_CLK) chk("busy_mid_frame", {7'b0, rx_busy}, 8'h01);
      rx = line[c / BIT_CLK];
      // Start is detected at edge SYNC+1; only later pulses advance the sampler.
      if (c + 1 > SYNC + 1 && baud_pulse) begin
        pulses++;
        if (pulses == dec_idx) load_now = 1'b1;
      end
      rd_strobe = load_now && rd_at_load;
      tick();
      if (load_now) begin
        model_load(e_data, e_perr, ~stop_v, rd_at_load);
        rd_strobe = 1'b0;
        load_now  = 1'b0;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    aresetn = 1'b0; baud_pulse = 1'b0; rx = 1'b1; rd_strobe = 1'b0;
    bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;
    model_reset();
    chk_on = 1'b1;
    repeat (4) tick();
    chk("reset_data", rx_data, 8'h00);
    chk("reset_flags", {3'b0, rx_valid, parity_err, framing_err, overrun, rx_busy}, 8'h00);
    aresetn = 1'b1;
    idle(2 * BIT_CLK);

    // 8N1 0xA5
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0, -1);
    idle(BIT_CLK);
    chk("a5_data", rx_data, 8'hA5);
    chk("a5_flags", {4'b0, rx_valid, parity_err, framing_err, overrun}, 8'h08);
    chk("a5_idle_busy", {7'b0, rx_busy}, 8'h00);
    do_read();
    chk("a5_read_valid", {7'b0, rx_valid}, 8'h00);
    do_read();  // read while empty: no effect
    idle(BIT_CLK);

    // 7E1 0x35: 4 ones, even parity expects 0
    bit8 = 1'b0; parity_en = 1'b1; odd_n_even = 1'b0;
    send_frame(8'h35, 1'b1, 1'b1, 1'b0, -1);
    idle(BIT_CLK);
    chk("7e1_bad_data", rx_data, 8'h35);
    chk("7e1_bad_perr", {7'b0, parity_err}, 8'h01);
    do_read();
    send_frame(8'h35, 1'b0, 1'b1, 1'b0, -1);
    idle(BIT_CLK);
    chk("7e1_good_perr", {7'b0, parity_err}, 8'h00);
    do_read();
    // 7-bit mode forces bit 7 low; 0xB5 -> 0x35, odd parity expects 1
    odd_n_even = 1'b1;
    send_frame(8'hB5, 1'b1, 1'b1, 1'b0, -1);
    idle(BIT_CLK);
    chk("7o1_data", rx_data, 8'h35);
    chk("7o1_perr", {7'b0, parity_err}, 8'h00);
    do_read();

    // 8N1 0x3C with stop low, then a 40-bit break
    bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, -1);
    chk("ferr_data", rx_data, 8'h3C);
    chk("ferr_flag", {7'b0, framing_err}, 8'h01);
    do_read();
    repeat (40 * BIT_CLK) tick();
    chk("break_valid", {7'b0, rx_valid}, 8'h00);
    chk("break_busy", {7'b0, rx_busy}, 8'h00);
    idle(2 * BIT_CLK);

    // Low glitch of 4 baud pulses
    rx = 1'b0;
    repeat (10) tick();
    chk("glitch_busy", {7'b0, rx_busy}, 8'h01);
    repeat (4 * P - 10) tick();
    idle(BIT_CLK);
    chk("glitch_idle", {7'b0, rx_busy}, 8'h00);
    chk("glitch_valid", {7'b0, rx_valid}, 8'h00);
    idle(BIT_CLK);

    // Overrun, then read coinciding with the second load
    send_frame(8'h11, 1'b0, 1'b1, 1'b0, -1);
    idle(BIT_CLK);
    send_frame(8'h22, 1'b0, 1'b1, 1'b0, -1);
    idle(BIT_CLK);
    chk("ovr_data", rx_data, 8'h11);
    chk("ovr_flag", {6'b0, rx_valid, overrun}, 8'h03);
    do_read();
    chk("ovr_cleared", {6'b0, rx_valid, overrun}, 8'h00);
    send_frame(8'h11, 1'b0, 1'b1, 1'b0, -1);
    idle(BIT_CLK);
    send_frame(8'h22, 1'b0, 1'b1, 1'b1, -1);
    idle(BIT_CLK);
    chk("rdload_data", rx_data, 8'h22);
    chk("rdload_flag", {6'b0, rx_valid, overrun}, 8'h02);

    // Reset in the middle of data bit 4
    send_frame(8'h77, 1'b0, 1'b1, 1'b0, 5 * BIT_CLK + BIT_CLK / 2);
    chk("rst_pre_busy", {7'b0, rx_busy}, 8'h01);
    aresetn = 1'b0;
    model_reset();
    #1;
    chk("rst_mid_data", rx_data, 8'h00);
    chk("rst_mid_flags", {3'b0, rx_valid, parity_err, framing_err, overrun, rx_busy}, 8'h00);
    rx = 1'b1;
    repeat (3) tick();
    aresetn = 1'b1;
    idle(2 * BIT_CLK);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0, -1);
    idle(BIT_CLK);
    chk("post_rst_data", rx_data, 8'h5A);
    chk("post_rst_flags", {4'b0, rx_valid, parity_err, framing_err, overrun}, 8'h08);

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
